// File: rtl/shift_reg_seq_if.sv
// Command handshake between the host/test logic and the shift-register sequencer.
interface shift_reg_seq_if #(
  parameter int CNT_W = 4
);
  logic             iReq;
  logic [1:0]       iOp;
  logic             iDir;
  logic [CNT_W-1:0] iCount;
  logic             iDump;
  logic             iClr;
  logic             oAck;
  logic             oBusy;
  logic             oDone;

  modport master (
    output iReq, iOp, iDir, iCount, iDump, iClr,
    input  oAck, oBusy, oDone
  );

  modport slave (
    input  iReq, iOp, iDir, iCount, iDump, iClr,
    output oAck, oBusy, oDone
  );
endinterface

// File: rtl/shift_reg_seq.sv
// Sequencer for the universal shift register: runs one command for a programmed number of
// cycles, then optionally reads back (and clears) every power counter.
module shift_reg_seq #(
  parameter int NUM_PWR = 5,
  parameter int CNT_W   = 4
) (
  input  logic           CLK,
  input  logic           RESETn,
  shift_reg_seq_if.slave cmd,
  output logic           oENB,
  output logic           oMODO1,
  output logic           oMODO0,
  output logic           oDIR,
  output logic [2:0]     oMemDir,
  output logic           oLE,
  output logic [31:0]    oMemDato,
  output logic           oMemOE,
  input  logic [31:0]    iMemDato,
  output logic [31:0]    oPwrData,
  output logic [2:0]     oPwrIdx,
  output logic           oPwrValid
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXEC    = 3'd1,
    S_DUMP_RD = 3'd2,
    S_DUMP_WR = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [1:0]       OP_LOAD   = 2'b00;
  localparam logic [1:0]       OP_SHIFT  = 2'b01;
  localparam logic [1:0]       OP_ROTATE = 2'b10;
  localparam logic [1:0]       OP_HOLD   = 2'b11;
  localparam logic [2:0]       LAST_IDX  = 3'(NUM_PWR - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             dir_q, dir_d;
  logic             dump_q, dump_d;
  logic             clr_q, clr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             enb_q, enb_d;
  logic             modo1_q, modo1_d;
  logic             modo0_q, modo0_d;
  logic             dir_out_q, dir_out_d;
  logic [2:0]       mem_dir_q, mem_dir_d;
  logic             le_q, le_d;
  logic [31:0]      mem_dato_q, mem_dato_d;
  logic             mem_oe_q, mem_oe_d;
  logic [31:0]      pwr_data_q, pwr_data_d;
  logic [2:0]       pwr_idx_q, pwr_idx_d;
  logic             pwr_valid_q, pwr_valid_d;

  // Next-state, command latching, cycle counting and counter capture.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    dir_d       = dir_q;
    dump_d      = dump_q;
    clr_d       = clr_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    ack_d       = 1'b0;
    pwr_data_d  = pwr_data_q;
    pwr_idx_d   = pwr_idx_q;
    pwr_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd.iReq) begin
          ack_d  = 1'b1;
          op_d   = cmd.iOp;
          dir_d  = cmd.iDir;
          dump_d = cmd.iDump;
          clr_d  = cmd.iClr & cmd.iDump;
          idx_d  = 3'd0;
          if (cmd.iOp == OP_LOAD) begin
            state_d = S_EXEC;
            cnt_d   = CNT_ONE;
          end else if (cmd.iCount != {CNT_W{1'b0}}) begin
            state_d = S_EXEC;
            cnt_d   = cmd.iCount;
          end else if (cmd.iDump) begin
            state_d = S_DUMP_RD;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        if (cnt_q <= CNT_ONE) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = dump_q ? S_DUMP_RD : S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DUMP_RD: begin
        pwr_data_d  = iMemDato;
        pwr_idx_d   = idx_q;
        pwr_valid_d = 1'b1;
        if (clr_q) begin
          state_d = S_DUMP_WR;
        end else if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      S_DUMP_WR: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = S_DUMP_RD;
        end
      end
      S_DONE: begin
        // A zero-count command lands here straight from IDLE and pulses oDone one cycle later.
        if (done_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    done_d = (state_d == S_DONE) && (state_q != S_IDLE);
  end

  // Output decode from the upcoming state so every output leaves a flop.
  always_comb begin
    enb_d      = 1'b0;
    modo1_d    = 1'b0;
    modo0_d    = 1'b0;
    dir_out_d  = 1'b0;
    mem_dir_d  = 3'd0;
    le_d       = 1'b1;
    mem_oe_d   = 1'b0;
    mem_dato_d = 32'd0;
    busy_d     = 1'b0;
    case (state_d)
      S_EXEC: begin
        busy_d    = 1'b1;
        dir_out_d = dir_d;
        case (op_d)
          OP_LOAD:   begin enb_d = 1'b1; modo1_d = 1'b1; end
          OP_SHIFT:  begin enb_d = 1'b1; end
          OP_ROTATE: begin enb_d = 1'b1; modo0_d = 1'b1; end
          OP_HOLD:   begin enb_d = 1'b0; end
          default:   begin enb_d = 1'b0; end
        endcase
      end
      S_DUMP_RD: begin
        busy_d    = 1'b1;
        mem_dir_d = idx_d;
      end
      S_DUMP_WR: begin
        busy_d    = 1'b1;
        mem_dir_d = idx_d;
        le_d      = 1'b0;
        mem_oe_d  = 1'b1;
      end
      S_DONE: begin
        busy_d = ~done_d;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset parks the memory port in read mode.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q     <= S_IDLE;
      op_q        <= 2'b00;
      dir_q       <= 1'b0;
      dump_q      <= 1'b0;
      clr_q       <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      idx_q       <= 3'd0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      enb_q       <= 1'b0;
      modo1_q     <= 1'b0;
      modo0_q     <= 1'b0;
      dir_out_q   <= 1'b0;
      mem_dir_q   <= 3'd0;
      le_q        <= 1'b1;
      mem_dato_q  <= 32'd0;
      mem_oe_q    <= 1'b0;
      pwr_data_q  <= 32'd0;
      pwr_idx_q   <= 3'd0;
      pwr_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      dir_q       <= dir_d;
      dump_q      <= dump_d;
      clr_q       <= clr_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      enb_q       <= enb_d;
      modo1_q     <= modo1_d;
      modo0_q     <= modo0_d;
      dir_out_q   <= dir_out_d;
      mem_dir_q   <= mem_dir_d;
      le_q        <= le_d;
      mem_dato_q  <= mem_dato_d;
      mem_oe_q    <= mem_oe_d;
      pwr_data_q  <= pwr_data_d;
      pwr_idx_q   <= pwr_idx_d;
      pwr_valid_q <= pwr_valid_d;
    end
  end

  assign cmd.oAck  = ack_q;
  assign cmd.oBusy = busy_q;
  assign cmd.oDone = done_q;
  assign oENB      = enb_q;
  assign oMODO1    = modo1_q;
  assign oMODO0    = modo0_q;
  assign oDIR      = dir_out_q;
  assign oMemDir   = mem_dir_q;
  assign oLE       = le_q;
  assign oMemDato  = mem_dato_q;
  assign oMemOE    = mem_oe_q;
  assign oPwrData  = pwr_data_q;
  assign oPwrIdx   = pwr_idx_q;
  assign oPwrValid = pwr_valid_q;

endmodule

// File: tb/tb_shift_reg_seq.sv
// Scoreboard bench for shift_reg_seq: directed commands push expected per-command
// summaries and dump records; a monitor pops and compares them as the DUT responds.
module tb_shift_reg_seq;
  localparam int NUM_PWR = 5;
  localparam int CNT_W   = 4;
  localparam logic [79:0] RESET_VEC = {10'b0000000001, 70'd0};

  typedef struct {
    int lat;
    int busy;
    int enb;
    int m1;
    int m0;
    int dirc;
    int wr;
  } exp_t;

  typedef struct {
    logic [2:0]  idx;
    logic [31:0] data;
  } pwr_t;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        oENB, oMODO1, oMODO0, oDIR, oLE, oMemOE, oPwrValid;
  logic [2:0]  oMemDir, oPwrIdx;
  logic [31:0] oMemDato, oPwrData, iMemDato;
  logic [31:0] mem [NUM_PWR];
  logic [31:0] load_vals [NUM_PWR];
  logic [31:0] shadow [NUM_PWR];
  logic        load_req = 1'b0;

  exp_t exp_q[$];
  pwr_t pwr_q[$];
  int   checks = 0;
  int   errors = 0;

  int   cyc, busy_c, enb_c, m1_c, m0_c, dir_c, wr_c;
  bit   active = 1'b0;

  shift_reg_seq_if #(.CNT_W(CNT_W)) cmd_if ();

  shift_reg_seq #(.NUM_PWR(NUM_PWR), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESETn(RESETn), .cmd(cmd_if.slave),
    .oENB(oENB), .oMODO1(oMODO1), .oMODO0(oMODO0), .oDIR(oDIR),
    .oMemDir(oMemDir), .oLE(oLE), .oMemDato(oMemDato), .oMemOE(oMemOE),
    .iMemDato(iMemDato), .oPwrData(oPwrData), .oPwrIdx(oPwrIdx), .oPwrValid(oPwrValid)
  );

  always #5 CLK = ~CLK;

  assign iMemDato = (int'(oMemDir) < NUM_PWR) ? mem[oMemDir] : 32'hBAD0_BAD0;

  // Counter memory model: preload from the bench, write on LE=0 with the bus driven by oMemDato.
  always @(posedge CLK) begin
    if (load_req) begin
      for (int i = 0; i < NUM_PWR; i++) mem[i] <= load_vals[i];
    end else if (RESETn && !oLE && int'(oMemDir) < NUM_PWR) begin
      mem[oMemDir] <= oMemOE ? oMemDato : 32'hDEAD_BEEF;
    end
  end

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [79:0] outs();
    return {cmd_if.oAck, cmd_if.oBusy, cmd_if.oDone, oENB, oMODO1, oMODO0, oDIR, oMemOE,
            oPwrValid, oLE, oMemDir, oMemDato, oPwrData, oPwrIdx};
  endfunction

  // Monitor: per-command activity summary compared on oDone, dump records on oPwrValid.
  always @(negedge CLK) begin
    if (!RESETn) begin
      active = 1'b0;
    end else begin
      chk("oe_iff_write", {79'd0, oMemOE}, {79'd0, ~oLE});
      if (oPwrValid) begin
        if (pwr_q.size() == 0) begin
          chk("unexpected_pwr_valid", 80'd1, 80'd0);
        end else begin
          pwr_t p;
          p = pwr_q.pop_front();
          chk("pwr_idx", {77'd0, oPwrIdx}, {77'd0, p.idx});
          chk("pwr_data", {48'd0, oPwrData}, {48'd0, p.data});
        end
      end
      if (cmd_if.oAck) begin
        active = 1'b1;
        cyc = 0; busy_c = 0; enb_c = 0; m1_c = 0; m0_c = 0; dir_c = 0; wr_c = 0;
      end
      if (active) begin
        if (cmd_if.oBusy) busy_c++;
        if (oENB) enb_c++;
        if (oMODO1) m1_c++;
        if (oMODO0) m0_c++;
        if (oDIR) dir_c++;
        if (!oLE) wr_c++;
        if (cmd_if.oDone) begin
          active = 1'b0;
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 80'd1, 80'd0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ack_to_done", 80'(cyc), 80'(e.lat));
            chk("busy_cycles", 80'(busy_c), 80'(e.busy));
            chk("enb_cycles", 80'(enb_c), 80'(e.enb));
            chk("modo1_cycles", 80'(m1_c), 80'(e.m1));
            chk("modo0_cycles", 80'(m0_c), 80'(e.m0));
            chk("dir_cycles", 80'(dir_c), 80'(e.dirc));
            chk("write_cycles", 80'(wr_c), 80'(e.wr));
          end
        end else begin
          cyc++;
        end
      end else if (cmd_if.oDone) begin
        chk("done_without_ack", 80'd1, 80'd0);
      end
    end
  end

  task automatic preload(input logic [31:0] a, b, c, d, e);
    load_vals[0] = a; load_vals[1] = b; load_vals[2] = c; load_vals[3] = d; load_vals[4] = e;
    for (int i = 0; i < NUM_PWR; i++) shadow[i] = load_vals[i];
    @(negedge CLK) load_req = 1'b1;
    @(negedge CLK) load_req = 1'b0;
  endtask

  task automatic push_exp(input logic dump, input logic clr, input int lat, busy, enb, m1, m0,
                          dirc, wr);
    exp_t e;
    pwr_t p;
    e.lat = lat; e.busy = busy; e.enb = enb; e.m1 = m1; e.m0 = m0; e.dirc = dirc; e.wr = wr;
    exp_q.push_back(e);
    if (dump) begin
      for (int i = 0; i < NUM_PWR; i++) begin
        p.idx = 3'(i);
        p.data = shadow[i];
        pwr_q.push_back(p);
        if (clr) shadow[i] = 32'd0;
      end
    end
  endtask

  task automatic drive_req(input logic [1:0] op, input logic dir, input logic [3:0] cnt,
                           input logic dump, input logic clr);
    cmd_if.iReq = 1'b1; cmd_if.iOp = op; cmd_if.iDir = dir;
    cmd_if.iCount = cnt; cmd_if.iDump = dump; cmd_if.iClr = clr;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (n < 60) begin
      @(posedge CLK); #1;
      if (cmd_if.oDone) break;
      n++;
    end
    if (n >= 60) chk({name, "_done_timeout"}, 80'd1, 80'd0);
    @(negedge CLK);
  endtask

  task automatic run_cmd(input string name, input logic [1:0] op, input logic dir,
                         input logic [3:0] cnt, input logic dump, input logic clr,
                         input int lat, busy, enb, m1, m0, dirc, wr);
    int n;
    push_exp(dump, clr, lat, busy, enb, m1, m0, dirc, wr);
    @(negedge CLK);
    drive_req(op, dir, cnt, dump, clr);
    n = 0;
    while (n < 20) begin
      @(posedge CLK); #1;
      if (cmd_if.oAck) break;
      n++;
    end
    cmd_if.iReq = 1'b0;
    if (n >= 20) chk({name, "_ack_timeout"}, 80'd1, 80'd0);
    wait_done(name);
  endtask

  initial begin
    cmd_if.iReq = 1'b0; cmd_if.iOp = 2'b00; cmd_if.iDir = 1'b0;
    cmd_if.iCount = 4'd0; cmd_if.iDump = 1'b0; cmd_if.iClr = 1'b0;
    repeat (3) @(negedge CLK);
    chk("in_reset_values", outs(), RESET_VEC);
    RESETn = 1'b1;
    repeat (5) @(negedge CLK);
    chk("idle_reset_values", outs(), RESET_VEC);
    chk("idle_le_high", {79'd0, oLE}, 80'd1);

    preload(32'd10, 32'd20, 32'd30, 32'd40, 32'd50);
    //       name        op     dir  cnt  dump  clr   lat busy enb m1 m0 dirc wr
    run_cmd("shift3",  2'b01, 1'b1, 4'd3, 1'b0, 1'b0,  3,  3,  3, 0, 0,  3, 0);
    run_cmd("load9",   2'b00, 1'b0, 4'd9, 1'b0, 1'b0,  1,  1,  1, 1, 0,  0, 0);
    run_cmd("hold0",   2'b11, 1'b1, 4'd0, 1'b0, 1'b0,  1,  1,  0, 0, 0,  0, 0);
    run_cmd("rot_dmp", 2'b10, 1'b0, 4'd2, 1'b1, 1'b0,  7,  7,  2, 0, 2,  0, 0);
    run_cmd("rot_clr", 2'b10, 1'b1, 4'd2, 1'b1, 1'b1, 12, 12,  2, 0, 2,  2, 5);
    run_cmd("shf_dmp", 2'b01, 1'b0, 4'd1, 1'b1, 1'b0,  6,  6,  1, 0, 0,  0, 0);
    run_cmd("hold15",  2'b11, 1'b1, 4'd15, 1'b0, 1'b0, 15, 15, 0, 0, 0, 15, 0);
    run_cmd("clr_only",2'b01, 1'b1, 4'd2, 1'b0, 1'b1,  2,  2,  2, 0, 0,  2, 0);
    preload(32'd1, 32'd2, 32'd3, 32'd4, 32'd5);
    run_cmd("hold0dmp",2'b11, 1'b1, 4'd0, 1'b1, 1'b0,  5,  5,  0, 0, 0,  0, 0);

    // Abort a long SHIFT with reset while a second request waits for its turn.
    @(negedge CLK);
    drive_req(2'b01, 1'b1, 4'd8, 1'b0, 1'b0);
    @(posedge CLK); #1;
    chk("abort_cmd_ack", {79'd0, cmd_if.oAck}, 80'd1);
    cmd_if.iReq = 1'b0;
    push_exp(1'b0, 1'b0, 1, 1, 0, 0, 0, 0, 0);
    @(negedge CLK);
    drive_req(2'b11, 1'b0, 4'd1, 1'b0, 1'b0);
    @(posedge CLK); #1;
    chk("busy_req_no_ack_c1", {79'd0, cmd_if.oAck}, 80'd0);
    @(posedge CLK); #1;
    chk("busy_req_no_ack_c2", {79'd0, cmd_if.oAck}, 80'd0);
    chk("still_shifting_c2", {79'd0, oENB}, 80'd1);
    #2 RESETn = 1'b0;
    #1 chk("mid_reset_values", outs(), RESET_VEC);
    @(negedge CLK) RESETn = 1'b1;
    @(posedge CLK); #1;
    chk("post_reset_accept", {79'd0, cmd_if.oAck}, 80'd1);
    cmd_if.iReq = 1'b0;
    wait_done("post_reset");
    repeat (3) @(negedge CLK);

    chk("exp_queue_drained", 80'(exp_q.size()), 80'd0);
    chk("pwr_queue_drained", 80'(pwr_q.size()), 80'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_reg_seq.md
# shift_reg_seq

Sequencer for the universal shift-register datapath. It accepts one command at a time over a req/ack handshake and drives the register's mode lines and enable for a programmed number of cycles: `ENB`, `MODO1`, `MODO0` and `DIR` to the mux/`ff_d` chain. After a command it can optionally dump the power-counter memory (`memTrans` port: dir/LE/dato) and optionally clear it. It sits between the test/host logic and the register plus counter memory.

## Interface
Parameters:
- `NUM_PWR`, 5: number of power-counter entries, indices 0..NUM_PWR-1.
- `CNT_W`, 4: width of the cycle-count field.

Ports:
- `CLK` in 1: single clock, all state changes on posedge.
- `RESETn` in 1: reset; one clock; reset is asynchronous and active-low.
- `iReq` in 1: command request, held high until `oAck`.
- `iOp` in 2: 00 LOAD, 01 SHIFT (serial in), 10 ROTATE (circular), 11 HOLD.
- `iDir` in 1: direction, passed to `oDIR`.
- `iCount` in CNT_W: number of execute cycles.
- `iDump` in 1: read all counters after execute.
- `iClr` in 1: with `iDump`, zero each counter after reading it; ignored without `iDump`.
- `oAck` out 1: one-cycle pulse, command accepted.
- `oBusy` out 1: command in progress.
- `oDone` out 1: one-cycle pulse, command finished.
- `oENB` out 1: shift-register enable.
- `oMODO1` out 1: shift-register mode line.
- `oMODO0` out 1: shift-register mode line.
- `oDIR` out 1: shift-register direction line.
- `oMemDir` out 3: counter memory address.
- `oLE` out 1: 1 = read, 0 = write.
- `oMemDato` out 32: write data.
- `oMemOE` out 1: top level drives `dato` from `oMemDato` when 1.
- `iMemDato` in 32: memory read data.
- `oPwrData` out 32: dumped counter value.
- `oPwrIdx` out 3: index of `oPwrData`.
- `oPwrValid` out 1: one-cycle qualifier for `oPwrData`/`oPwrIdx`.

## Operation
- States:
  - IDLE → EXEC when `iReq`=1.
  - EXEC → DUMP_RD when the count expires and `iDump`=1; otherwise EXEC → DONE.
  - DUMP_RD → DUMP_WR when `iClr`=1, else to the next index.
  - DUMP_WR → next index.
  - After the last index → DONE.
  - DONE → IDLE.
- IDLE with `iReq`=1 at an edge:
  - Latch op, dir, count, dump, clr.
  - `oAck`=1 for one cycle; `oBusy`=1.
- EXEC drives, per op:
  - LOAD: `oENB`=1, MODO1/MODO0 = 1/0. Always exactly 1 cycle; `iCount` ignored.
  - SHIFT: `oENB`=1, MODO1/MODO0 = 0/0, for `iCount` cycles.
  - ROTATE: `oENB`=1, MODO1/MODO0 = 0/1, for `iCount` cycles.
  - HOLD: `oENB`=0, MODO1/MODO0 = 0/0, for `iCount` cycles.
  - `oDIR` = latched dir for all ops.
- `iCount`=0 for SHIFT/ROTATE/HOLD: EXEC is skipped and `oENB` never asserts. The FSM goes from IDLE directly to DUMP_RD or DONE.
- Outside EXEC: `oENB`=0, MODO1/MODO0/DIR = 0.
- DUMP_RD, index i:
  - `oMemDir`=i, `oLE`=1, `oMemOE`=0.
  - At the end of the cycle, capture `iMemDato` into `oPwrData`, set `oPwrIdx`=i, `oPwrValid`=1 for the next cycle.
- DUMP_WR, index i: `oMemDir`=i, `oLE`=0, `oMemOE`=1, `oMemDato`=0.
- Invariant: `oMemOE`=1 if and only if `oLE`=0. The controller never writes outside DUMP_WR.
- DONE: `oDone`=1, `oBusy`=0, for one cycle. `iReq` is not accepted in DONE.
- `iReq` while busy: ignored, no `oAck`; the requester keeps it high.
- Cycle counter: CNT_W bits. It counts down from `iCount` and never wraps; the maximum is 2^CNT_W−1 cycles.

## Timing
- Reset values (asynchronous, on `RESETn`=0):
  - State IDLE.
  - `oAck`, `oBusy`, `oDone`, `oENB`, `oMODO1`, `oMODO0`, `oDIR`, `oMemOE`, `oPwrValid` = 0.
  - `oLE`=1.
  - `oMemDir`, `oMemDato`, `oPwrData`, `oPwrIdx` = 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Command accepted at edge k:
  - `oAck`, `oBusy` and the first EXEC cycle all start at k.
  - `oENB` is high for cycles k .. k+N−1.
  - Without dump, `oDone` is high during cycle k+N.
- Dump adds NUM_PWR cycles (read only) or 2·NUM_PWR cycles (read and clear) before DONE.
- `oPwrValid` for index i is high during the cycle after its DUMP_RD cycle. With clear, this overlaps that index's DUMP_WR cycle.
- `iMemDato` is sampled at the edge ending DUMP_RD. The memory read path must settle within one `CLK` period.
- Reset asserted mid-command (EXEC or DUMP):
  - Immediate return to reset values with `oLE`=1, so no partial write is possible.
  - The aborted command produces no `oDone`.

## Test plan
- Reset, then idle for 5 cycles → all outputs at reset values; `oLE`=1; `oENB`=0.
- SHIFT, `iCount`=3, `iDir`=1 at edge 0 → `oAck` at cycle 0; `oENB`=1 with MODO=00 and `oDIR`=1 for cycles 0–2; `oDone` at cycle 3; `oBusy` low from cycle 3.
- LOAD with `iCount`=9, then HOLD with `iCount`=0 → LOAD gives `oENB` for exactly 1 cycle with MODO1=1. HOLD gives no `oENB`, and `oDone` one cycle after `oAck`.
- ROTATE, `iCount`=2, `iDump`=1, memory preloaded with 10, 20, 30, 40, 50 → MODO0=1 for 2 cycles, then 5 `oPwrValid` pulses with (idx, data) = (0,10)..(4,50), then `oDone`.
- Same as above plus `iClr`=1 → each read is followed by one `oLE`=0/`oMemOE`=1 cycle. A following dump returns all zeros.
- `RESETn` pulsed low during cycle 2 of SHIFT `iCount`=8; a second `iReq` held during busy → immediate reset values and no `oDone`. Busy-time `iReq` gets no `oAck`; that request is accepted on the first IDLE edge after reset.
